// File: rtl/lsu_mem_ctrl.sv
// Load/store control stage in front of the byte-addressed data RAM.
// Takes one request at a time, flags misaligned and out-of-range accesses,
// drives the RAM for one cycle and returns one registered, extended response.
module lsu_mem_ctrl #(
    parameter int XLEN      = 64,
    parameter int RAM_BYTES = 1024
) (
    input  logic            clk,
    input  logic            rst_n,
    input  logic            req_valid_i,
    output logic            req_ready_o,
    input  logic            req_wen_i,
    input  logic [XLEN-1:0] req_addr_i,
    input  logic [XLEN-1:0] req_wdata_i,
    input  logic [1:0]      req_size_i,
    input  logic            req_unsigned_i,
    output logic            resp_valid_o,
    input  logic            resp_ready_i,
    output logic [XLEN-1:0] resp_rdata_o,
    output logic            resp_misalign_o,
    output logic            resp_range_o,
    output logic [XLEN-1:0] ram_addr_o,
    output logic            ram_wen_o,
    output logic [XLEN-1:0] ram_wdata_o,
    output logic [1:0]      ram_wmask_o,
    input  logic [XLEN-1:0] ram_rdata_i
);

    typedef enum logic [1:0] {IDLE, ACCESS, RESP} state_t;

    state_t          state_q, state_d;
    logic            wen_q, uns_q, mis_q, rng_q;
    logic [1:0]      size_q;
    logic [XLEN-1:0] addr_q, wdata_q, rdata_q, rdata_d;
    logic [XLEN-1:0] lane_mask;
    logic [XLEN:0]   end_addr;
    logic            mis_in, rng_in, accept;

    // Sign- or zero-extend the low 8<<size bits of the RAM read data.
    function automatic logic [XLEN-1:0] load_extend(input logic [XLEN-1:0] raw,
                                                    input logic [1:0]      size,
                                                    input logic            uns);
        logic [XLEN-1:0] r;
        r = raw;
        case (size)
            2'd0:    r = uns ? XLEN'(raw[7:0])  : {{(XLEN-8){raw[7]}},   raw[7:0]};
            2'd1:    r = uns ? XLEN'(raw[15:0]) : {{(XLEN-16){raw[15]}}, raw[15:0]};
            2'd2:    r = uns ? XLEN'(raw[31:0]) : {{(XLEN-32){raw[31]}}, raw[31:0]};
            default: r = raw;
        endcase
        return r;
    endfunction

    // Fault detection on the incoming request; the end address is one bit wider so wrap-around is out of range.
    always_comb begin
        lane_mask = (XLEN'(1) << req_size_i) - XLEN'(1);
        mis_in    = |(req_addr_i & lane_mask);
        end_addr  = {1'b0, req_addr_i} + ((XLEN+1)'(1) << req_size_i);
        rng_in    = end_addr > (XLEN+1)'(RAM_BYTES);
    end

    // Next-state logic and handshake outputs; RAM writes only happen in ACCESS.
    always_comb begin
        state_d      = state_q;
        req_ready_o  = 1'b0;
        resp_valid_o = 1'b0;
        ram_wen_o    = 1'b0;
        accept       = 1'b0;
        case (state_q)
            IDLE: begin
                req_ready_o = 1'b1;
                accept      = req_valid_i;
                if (req_valid_i) begin
                    state_d = (mis_in || rng_in) ? RESP : ACCESS;
                end
            end
            ACCESS: begin
                ram_wen_o = wen_q;
                state_d   = RESP;
            end
            RESP: begin
                resp_valid_o = 1'b1;
                if (resp_ready_i) begin
                    state_d = IDLE;
                end
            end
            default: state_d = IDLE;
        endcase
    end

    // Response data: cleared on accept, loaded with extended read data at the end of ACCESS.
    always_comb begin
        rdata_d = rdata_q;
        if (accept) begin
            rdata_d = '0;
        end else if (state_q == ACCESS) begin
            rdata_d = wen_q ? '0 : load_extend(ram_rdata_i, size_q, uns_q);
        end
    end

    // State register.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q <= IDLE;
        end else begin
            state_q <= state_d;
        end
    end

    // Request capture and fault flags, updated only when a request is accepted.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            wen_q   <= 1'b0;
            uns_q   <= 1'b0;
            size_q  <= 2'd0;
            addr_q  <= '0;
            wdata_q <= '0;
            mis_q   <= 1'b0;
            rng_q   <= 1'b0;
        end else if (accept) begin
            wen_q   <= req_wen_i;
            uns_q   <= req_unsigned_i;
            size_q  <= req_size_i;
            addr_q  <= req_addr_i;
            wdata_q <= req_wdata_i;
            mis_q   <= mis_in;
            rng_q   <= rng_in;
        end
    end

    // Response data register.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            rdata_q <= '0;
        end else begin
            rdata_q <= rdata_d;
        end
    end

    assign ram_addr_o      = addr_q;
    assign ram_wmask_o     = size_q;
    assign ram_wdata_o     = wdata_q;
    assign resp_rdata_o    = rdata_q;
    assign resp_misalign_o = mis_q;
    assign resp_range_o    = rng_q;

endmodule

// File: tb/tb_lsu_mem_ctrl.sv
// Testbench for lsu_mem_ctrl: behavioural RAM, byte-level reference memory,
// directed scenarios followed by randomized requests.
module tb_lsu_mem_ctrl;

    logic        clk = 1'b0;
    logic        rst_n;
    logic        req_valid_i, req_ready_o, req_wen_i, req_unsigned_i;
    logic [63:0] req_addr_i, req_wdata_i;
    logic [1:0]  req_size_i;
    logic        resp_valid_o, resp_ready_i, resp_misalign_o, resp_range_o;
    logic [63:0] resp_rdata_o;
    logic [63:0] ram_addr_o, ram_wdata_o, ram_rdata_i;
    logic        ram_wen_o;
    logic [1:0]  ram_wmask_o;

    int n_total = 0;
    int n_bad   = 0;
    int wen_cnt = 0;
    logic ram_init;

    logic [7:0] mem     [0:1023];
    logic [7:0] ref_mem [0:1023];

    always #5 clk = ~clk;

    lsu_mem_ctrl #(.XLEN(64), .RAM_BYTES(1024)) dut (
        .clk(clk), .rst_n(rst_n),
        .req_valid_i(req_valid_i), .req_ready_o(req_ready_o),
        .req_wen_i(req_wen_i), .req_addr_i(req_addr_i), .req_wdata_i(req_wdata_i),
        .req_size_i(req_size_i), .req_unsigned_i(req_unsigned_i),
        .resp_valid_o(resp_valid_o), .resp_ready_i(resp_ready_i),
        .resp_rdata_o(resp_rdata_o), .resp_misalign_o(resp_misalign_o),
        .resp_range_o(resp_range_o),
        .ram_addr_o(ram_addr_o), .ram_wen_o(ram_wen_o), .ram_wdata_o(ram_wdata_o),
        .ram_wmask_o(ram_wmask_o), .ram_rdata_i(ram_rdata_i)
    );

    // Behavioural RAM: combinational little-endian read, write at the clock edge.
    always_comb begin
        ram_rdata_i = '0;
        for (int i = 0; i < 8; i++) begin
            ram_rdata_i[i*8 +: 8] = mem[10'(ram_addr_o + 64'(i))];
        end
    end

    always @(posedge clk) begin
        if (ram_init) begin
            for (int i = 0; i < 1024; i++) mem[i] <= 8'(i * 37 + 5);
        end else if (ram_wen_o) begin
            for (int i = 0; i < (1 << ram_wmask_o); i++)
                mem[10'(ram_addr_o + 64'(i))] <= ram_wdata_o[i*8 +: 8];
        end
    end

    // Count cycles in which the RAM sees a write enable.
    always @(negedge clk) begin
        if (ram_wen_o) wen_cnt <= wen_cnt + 1;
    end

    task automatic chk(input string tag, input logic [63:0] got, input logic [63:0] exp);
        n_total++;
        if (got !== exp) begin
            n_bad++;
            $display("FAIL %s: got=0x%016h expected=0x%016h", tag, got, exp);
        end
    endtask

    // Reference: byte-array memory and arithmetic fault/extension rules.
    task automatic model(input logic wen, input logic [63:0] addr, input logic [63:0] wdata,
                         input logic [1:0] size, input logic uns,
                         output logic mis, output logic rng, output logic [63:0] rdata);
        logic [63:0] nb, v;
        nb    = 64'd1 << size;
        mis   = (addr % nb) != 0;
        rng   = addr > (64'd1024 - nb);
        rdata = '0;
        if (!mis && !rng) begin
            if (wen) begin
                for (int i = 0; i < int'(nb); i++) ref_mem[addr + 64'(i)] = 8'(wdata >> (8 * i));
            end else begin
                v = 0;
                for (int i = 0; i < int'(nb); i++) v = v | (64'(ref_mem[addr + 64'(i)]) << (8 * i));
                if (!uns && size != 2'd3 && ((v >> (8 * nb - 1)) & 64'd1) == 64'd1)
                    v = v | ~((64'd1 << (8 * nb)) - 64'd1);
                rdata = v;
            end
        end
    endtask

    task automatic check_reset_outputs(input string p);
        chk({p, "_req_ready"}, 64'(req_ready_o), 64'd1);
        chk({p, "_resp_valid"}, 64'(resp_valid_o), 64'd0);
        chk({p, "_rdata"}, resp_rdata_o, 64'd0);
        chk({p, "_misalign"}, 64'(resp_misalign_o), 64'd0);
        chk({p, "_range"}, 64'(resp_range_o), 64'd0);
        chk({p, "_ram_addr"}, ram_addr_o, 64'd0);
        chk({p, "_ram_wen"}, 64'(ram_wen_o), 64'd0);
        chk({p, "_ram_wdata"}, ram_wdata_o, 64'd0);
        chk({p, "_ram_wmask"}, 64'(ram_wmask_o), 64'd0);
    endtask

    // One full request/response; called at posedge+1 with the DUT idle.
    task automatic txn(input logic wen, input logic [63:0] addr, input logic [63:0] wdata,
                       input logic [1:0] size, input logic uns, input int hold);
        logic emis, erng, fault;
        logic [63:0] erd;
        int w0;
        model(wen, addr, wdata, size, uns, emis, erng, erd);
        fault = emis | erng;
        w0 = wen_cnt;
        chk("idle_ready", 64'(req_ready_o), 64'd1);
        req_valid_i = 1'b1; req_wen_i = wen; req_addr_i = addr;
        req_wdata_i = wdata; req_size_i = size; req_unsigned_i = uns;
        @(posedge clk); #1;
        req_valid_i = 1'b0;
        if (!fault) begin
            chk("acc_valid", 64'(resp_valid_o), 64'd0);
            chk("acc_wen", 64'(ram_wen_o), 64'(wen));
            chk("acc_addr", ram_addr_o, addr);
            chk("acc_mask", 64'(ram_wmask_o), 64'(size));
            if (wen) chk("acc_wdata", ram_wdata_o, wdata);
            @(posedge clk); #1;
        end else begin
            chk("flt_wen", 64'(ram_wen_o), 64'd0);
        end
        chk("resp_valid", 64'(resp_valid_o), 64'd1);
        chk("resp_req_ready", 64'(req_ready_o), 64'd0);
        chk("resp_misalign", 64'(resp_misalign_o), 64'(emis));
        chk("resp_range", 64'(resp_range_o), 64'(erng));
        chk("resp_rdata", resp_rdata_o, erd);
        for (int k = 0; k < hold; k++) begin
            req_valid_i = 1'b1;
            @(posedge clk); #1;
            chk("bp_valid", 64'(resp_valid_o), 64'd1);
            chk("bp_req_ready", 64'(req_ready_o), 64'd0);
            chk("bp_rdata", resp_rdata_o, erd);
        end
        req_valid_i  = 1'b0;
        resp_ready_i = 1'b1;
        @(posedge clk); #1;
        resp_ready_i = 1'b0;
        chk("done_valid", 64'(resp_valid_o), 64'd0);
        chk("done_req_ready", 64'(req_ready_o), 64'd1);
        chk("wen_cycles", 64'(wen_cnt - w0), (wen && !fault) ? 64'd1 : 64'd0);
    endtask

    initial begin
        logic [63:0] a, wd;
        logic [1:0]  sz;
        logic        dummy_m, dummy_r;
        logic [63:0] dummy_d;
        int w0;
        for (int i = 0; i < 1024; i++) ref_mem[i] = 8'(i * 37 + 5);
        rst_n = 1'b0; ram_init = 1'b1;
        req_valid_i = 0; req_wen_i = 0; req_addr_i = 0; req_wdata_i = 0;
        req_size_i = 0; req_unsigned_i = 0; resp_ready_i = 0;
        repeat (3) @(posedge clk);
        #1;
        check_reset_outputs("reset");
        ram_init = 1'b0; rst_n = 1'b1;
        @(posedge clk); #1;

        txn(1, 64'h10, 64'h1122334455667788, 2'd3, 0, 0);
        txn(0, 64'h10, 64'h0, 2'd3, 0, 0);
        chk("dbl_load_value", resp_rdata_o, 64'h1122334455667788);
        txn(1, 64'h10, 64'h80, 2'd0, 0, 0);
        txn(0, 64'h10, 64'h0, 2'd0, 0, 0);
        chk("sbyte_value", resp_rdata_o, 64'hFFFFFFFFFFFFFF80);
        txn(0, 64'h10, 64'h0, 2'd0, 1, 0);
        chk("ubyte_value", resp_rdata_o, 64'h0000000000000080);
        txn(0, 64'h12, 64'h0, 2'd2, 0, 0);
        txn(1, 64'd1020, 64'hDEADBEEFCAFEF00D, 2'd3, 0, 1);
        txn(0, 64'd1016, 64'h0, 2'd3, 0, 0);
        txn(0, 64'hFFFFFFFFFFFFFFF8, 64'h0, 2'd3, 0, 0);
        txn(0, 64'h12, 64'h0, 2'd1, 0, 5);

        // Store to 0x20 interrupted by reset while in ACCESS.
        model(0, 64'h20, 64'h0, 2'd3, 0, dummy_m, dummy_r, dummy_d);
        w0 = wen_cnt;
        req_valid_i = 1'b1; req_wen_i = 1'b1; req_addr_i = 64'h20;
        req_wdata_i = 64'hA5A5A5A5A5A5A5A5; req_size_i = 2'd3; req_unsigned_i = 1'b0;
        @(posedge clk); #1;
        req_valid_i = 1'b0;
        chk("rst_pre_wen", 64'(ram_wen_o), 64'd1);
        rst_n = 1'b0;
        #1;
        check_reset_outputs("midrst");
        @(negedge clk);
        rst_n = 1'b1;
        @(posedge clk); #1;
        chk("midrst_wen_cycles", 64'(wen_cnt - w0), 64'd0);
        txn(0, 64'h20, 64'h0, 2'd3, 0, 0);
        chk("midrst_old_value", resp_rdata_o, dummy_d);

        for (int n = 0; n < 80; n++) begin
            sz = 2'($urandom_range(0, 3));
            case ($urandom_range(0, 9))
                0:       a = 64'($urandom_range(0, 1023));
                1:       a = 64'd1024 - 64'($urandom_range(0, 15));
                2:       a = {$urandom, $urandom};
                default: a = 64'($urandom_range(0, 1023)) & ~((64'd1 << sz) - 64'd1);
            endcase
            wd = {$urandom, $urandom};
            txn(1'($urandom_range(0, 1)), a, wd, sz, 1'($urandom_range(0, 1)),
                int'($urandom_range(0, 3)));
        end

        $display("test done: total=%0d bad=%0d", n_total, n_bad);
        $finish;
    end

endmodule
